// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single GPR write port between the WB stage and a long-latency
//   unit (divider/multiplier). LU results land in a one-entry buffer and are
//   written whenever WB leaves the port idle. A starvation counter holds WB
//   for one cycle so a buffered result cannot wait forever.
//
// Ports
//   clk, resetn                  clock (posedge), async active-low reset
//   ws_rf_we/waddr/wdata         WB write request
//   ws_hold                      forces WB to stall and keep its request stable
//   lu_valid/waddr/wdata         LU result offer
//   lu_ready                     buffer can take an LU result this cycle
//   rf_we/waddr/wdata            regfile write port (ws_to_rf_bus)
//   buf_busy/buf_waddr           buffered result pending, for RAW stall in ID
module rf_wport_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_rf_we,
    input  logic [4:0]  ws_rf_waddr,
    input  logic [31:0] ws_rf_wdata,
    output logic        ws_hold,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        buf_busy,
    output logic [4:0]  buf_waddr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, cnt_nxt;
    logic [4:0]       buf_waddr_q;
    logic [31:0]      buf_wdata_q;
    logic             buf_valid;
    logic             drain;
    logic             accept;

    // The buffer is full in every state except IDLE.
    assign buf_valid = (state != S_IDLE);

    // Buffer owns the port when forced, or when WB has nothing to write.
    assign drain   = (state == S_FORCE) || ((state == S_PEND) && !ws_rf_we);
    assign ws_hold = (state == S_FORCE);

    // Draining frees the entry in the same cycle, so it can refill at once.
    assign lu_ready = !buf_valid || drain;
    assign accept   = lu_valid && lu_ready;

    // A buffered $0 result still drains but must not write. Nothing writes
    // while reset is asserted.
    assign rf_we    = resetn && (drain ? (buf_waddr_q != 5'd0) : ws_rf_we);
    assign rf_waddr = drain ? buf_waddr_q : ws_rf_waddr;
    assign rf_wdata = drain ? buf_wdata_q : ws_rf_wdata;

    assign buf_busy  = buf_valid;
    assign buf_waddr = buf_waddr_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = starve_cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = S_PEND;
            end
            S_PEND: begin
                if (drain) begin
                    cnt_nxt   = '0;
                    state_nxt = accept ? S_PEND : S_IDLE;
                end else begin
                    // WB won while the buffer waits: count the denial.
                    cnt_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + CNT_W'(1);
                    if (cnt_nxt == LIMIT) state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                // Always drains, so FORCE never lasts more than one cycle.
                cnt_nxt   = '0;
                state_nxt = accept ? S_PEND : S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            buf_waddr_q <= 5'd0;
            buf_wdata_q <= 32'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
            if (accept) begin
                buf_waddr_q <= lu_waddr;
                buf_wdata_q <= lu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ws_rf_we = 1'b0;
    logic [4:0]  ws_rf_waddr = 5'd0;
    logic [31:0] ws_rf_wdata = 32'd0;
    logic        ws_hold;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_waddr = 5'd0;
    logic [31:0] lu_wdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        buf_busy;
    logic [4:0]  buf_waddr;

    rf_wport_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata),
        .ws_hold(ws_hold),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .buf_busy(buf_busy), .buf_waddr(buf_waddr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: one pending LU result and how many cycles WB has beaten it.
    logic        m_full = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    int          m_wait = 0;

    // Last observed DUT outputs, for the hand-computed directed checks.
    logic        o_we, o_hold, o_rdy, o_busy;
    logic [4:0]  o_waddr, o_bwaddr;
    logic [31:0] o_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model
    // on the falling edge, then advance the model on the rising edge.
    task automatic step(input logic rn, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic lv, input logic [4:0] la,
                        input logic [31:0] ld);
        logic        force_w, gbuf, e_rdy, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        resetn = rn; ws_rf_we = we; ws_rf_waddr = wa; ws_rf_wdata = wd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
        if (!rn) begin
            m_full = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_wait = 0;
        end
        @(negedge clk);
        force_w = m_full && (m_wait >= LIMIT);
        gbuf    = m_full && (force_w || !we);
        e_rdy   = !m_full || gbuf;
        e_we    = rn && (gbuf ? (m_addr != 5'd0) : we);
        e_wa    = gbuf ? m_addr : wa;
        e_wd    = gbuf ? m_data : wd;
        chk("ws_hold",  {31'd0, ws_hold},  {31'd0, force_w});
        chk("lu_ready", {31'd0, lu_ready}, {31'd0, e_rdy});
        chk("rf_we",    {31'd0, rf_we},    {31'd0, e_we});
        chk("buf_busy", {31'd0, buf_busy}, {31'd0, m_full});
        if (e_we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_wa});
            chk("rf_wdata", rf_wdata, e_wd);
        end
        if (m_full || !rn) chk("buf_waddr", {27'd0, buf_waddr}, {27'd0, m_addr});
        o_we = rf_we; o_hold = ws_hold; o_rdy = lu_ready; o_busy = buf_busy;
        o_waddr = rf_waddr; o_wdata = rf_wdata; o_bwaddr = buf_waddr;
        @(posedge clk);
        if (rn) begin
            if (gbuf) begin
                m_full = 1'b0; m_wait = 0;
            end else if (m_full && we) begin
                m_wait = (m_wait >= LIMIT) ? LIMIT : m_wait + 1;
            end
            if (lv && e_rdy) begin
                m_full = 1'b1; m_addr = la; m_data = ld; m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        // 1: reset with an LU offer present
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hDEAD);
        chk("t1_we",   {31'd0, o_we},   32'd0);
        chk("t1_busy", {31'd0, o_busy}, 32'd0);
        chk("t1_rdy",  {31'd0, o_rdy},  32'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hDEAD);
        idle();
        chk("t1_idle_busy", {31'd0, o_busy}, 32'd0);

        // 2: LU result into an idle WB slot
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        chk("t2_t_we", {31'd0, o_we}, 32'd0);
        idle();
        chk("t2_t1_we",    {31'd0, o_we},  32'd1);
        chk("t2_t1_waddr", {27'd0, o_waddr}, 32'd5);
        chk("t2_t1_wdata", o_wdata, 32'h1234);
        chk("t2_t1_busy",  {31'd0, o_busy}, 32'd1);
        idle();
        chk("t2_t2_busy",  {31'd0, o_busy}, 32'd0);

        // 3: starvation; r8 offered while starved, accepted on the forced drain
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'd0);
            chk("t3_win_hold",  {31'd0, o_hold}, 32'd0);
            chk("t3_win_waddr", {27'd0, o_waddr}, 32'd9);
        end
        step(1'b1, 1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd8, 32'h8888);
        chk("t3_4_hold", {31'd0, o_hold}, 32'd0);
        chk("t3_4_rdy",  {31'd0, o_rdy},  32'd0);
        step(1'b1, 1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd8, 32'h8888);
        chk("t3_5_hold",  {31'd0, o_hold}, 32'd1);
        chk("t3_5_we",    {31'd0, o_we},   32'd1);
        chk("t3_5_waddr", {27'd0, o_waddr}, 32'd7);
        chk("t3_5_wdata", o_wdata, 32'h7777);
        chk("t3_5_rdy",   {31'd0, o_rdy},  32'd1);
        step(1'b1, 1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'd0);
        chk("t3_6_hold",  {31'd0, o_hold}, 32'd0);
        chk("t3_6_waddr", {27'd0, o_waddr}, 32'd9);
        chk("t3_6_bwaddr", {27'd0, o_bwaddr}, 32'd8);
        idle();
        chk("t3_7_waddr", {27'd0, o_waddr}, 32'd8);
        chk("t3_7_wdata", o_wdata, 32'h8888);
        idle();
        chk("t3_8_busy", {31'd0, o_busy}, 32'd0);

        // 4: back-to-back LU results
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333);
        chk("t4_0_rdy", {31'd0, o_rdy}, 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444);
        chk("t4_1_rdy",   {31'd0, o_rdy}, 32'd1);
        chk("t4_1_waddr", {27'd0, o_waddr}, 32'd3);
        idle();
        chk("t4_2_rdy",   {31'd0, o_rdy}, 32'd1);
        chk("t4_2_waddr", {27'd0, o_waddr}, 32'd4);
        chk("t4_2_wdata", o_wdata, 32'h4444);
        idle();
        chk("t4_3_busy", {31'd0, o_busy}, 32'd0);

        // 5: $0 result drains silently
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
        idle();
        chk("t5_we",   {31'd0, o_we},   32'd0);
        chk("t5_busy", {31'd0, o_busy}, 32'd1);
        idle();
        chk("t5_clr",  {31'd0, o_busy}, 32'd0);

        // 6: reset while a result is pending
        step(1'b1, 1'b1, 5'd10, 32'hBBBB, 1'b1, 5'd6, 32'h6666);
        chk("t6_wb_waddr", {27'd0, o_waddr}, 32'd10);
        step(1'b1, 1'b1, 5'd10, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        chk("t6_pend_busy", {31'd0, o_busy}, 32'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("t6_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("t6_rst_we",   {31'd0, o_we},   32'd0);
        idle();
        chk("t6_post_we",   {31'd0, o_we},   32'd0);
        chk("t6_post_busy", {31'd0, o_busy}, 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
